// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the MIPS fetch stage: FSM states, the NOP
// word and the primary opcode values seen in instr[31:26].
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    localparam logic [5:0] OPCODE_SPECIAL = 6'h00;
    localparam logic [5:0] OPCODE_REGIMM  = 6'h01;
    localparam logic [5:0] OPCODE_J       = 6'h02;
    localparam logic [5:0] OPCODE_JAL     = 6'h03;
    localparam logic [5:0] OPCODE_BEQ     = 6'h04;
    localparam logic [5:0] OPCODE_BNE     = 6'h05;
    localparam logic [5:0] OPCODE_BLEZ    = 6'h06;
    localparam logic [5:0] OPCODE_BGTZ    = 6'h07;
    localparam logic [5:0] OPCODE_ADDIU   = 6'h09;
    localparam logic [5:0] OPCODE_SLTI    = 6'h0A;
    localparam logic [5:0] OPCODE_SLTIU   = 6'h0B;
    localparam logic [5:0] OPCODE_ANDI    = 6'h0C;
    localparam logic [5:0] OPCODE_ORI     = 6'h0D;
    localparam logic [5:0] OPCODE_XORI    = 6'h0E;
    localparam logic [5:0] OPCODE_LUI     = 6'h0F;
    localparam logic [5:0] OPCODE_LB      = 6'h20;
    localparam logic [5:0] OPCODE_LH      = 6'h21;
    localparam logic [5:0] OPCODE_LW      = 6'h23;
    localparam logic [5:0] OPCODE_LBU     = 6'h24;
    localparam logic [5:0] OPCODE_LHU     = 6'h25;
    localparam logic [5:0] OPCODE_SB      = 6'h28;
    localparam logic [5:0] OPCODE_SH      = 6'h29;
    localparam logic [5:0] OPCODE_SW      = 6'h2B;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter with one-deep delayed-branch buffer: a redirect taken at a
// consume is applied after the following (delay-slot) instruction.
module pc_register
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        consume,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    logic        pending;
    logic [31:0] pending_target;

    assign pc_plus4 = pc + 32'd4;
    assign next_pc  = pending ? pending_target : pc_plus4;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc             <= RESET_VECTOR;
            pending        <= 1'b0;
            pending_target <= 32'h0;
        end else if (consume) begin
            pc <= next_pc;
            // A new redirect replaces the buffered one; the old target still drives this step.
            if (redirect_valid) begin
                pending        <= 1'b1;
                pending_target <= align_word(redirect_target);
            end else begin
                pending        <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: FETCH/HOLD/HALTED controller, instruction register and
// decoded fields, with the PC and delay-slot logic in pc_register.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter logic [31:0] HALT_ADDR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instr_address,
    output logic        instr_read,
    input  logic        instr_waitrequest,
    input  logic [31:0] instr_readdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [15:0] itype_immediate,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        active
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic         consume;
    logic         fetch_done;
    logic [31:0]  next_pc;

    assign fetch_done = (state == FETCH) && !instr_waitrequest;
    assign consume    = (state == HOLD) && !stall;

    pc_register #(
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_register (
        .clk             (clk),
        .reset           (reset),
        .consume         (consume),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc              (pc),
        .pc_plus4        (pc_plus4),
        .next_pc         (next_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            FETCH:   if (!instr_waitrequest) state_next = HOLD;
            HOLD:    if (!stall) state_next = (next_pc == HALT_ADDR) ? HALTED : FETCH;
            HALTED:  state_next = HALTED;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr <= INSTR_NOP;
        end else if (fetch_done) begin
            instr <= instr_readdata;
        end
    end

    // Reset drops the request immediately so an in-flight read is abandoned.
    assign instr_read      = (state == FETCH) && !reset;
    assign instr_valid     = (state == HOLD);
    assign active          = (state != HALTED);
    assign instr_address   = pc;
    assign opcode          = instr[31:26];
    assign itype_immediate = instr[15:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, hand-written
// reset/wrap sequences and a randomized run against a queue-based PC model.
module tb_instruction_fetch;

    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_address;
    logic        instr_read;
    logic        instr_waitrequest;
    logic [31:0] instr_readdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [15:0] itype_immediate;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        active;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk               (clk),
        .reset             (reset),
        .instr_address     (instr_address),
        .instr_read        (instr_read),
        .instr_waitrequest (instr_waitrequest),
        .instr_readdata    (instr_readdata),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .instr_valid       (instr_valid),
        .instr             (instr),
        .opcode            (opcode),
        .itype_immediate   (itype_immediate),
        .pc                (pc),
        .pc_plus4          (pc_plus4),
        .active            (active)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RV) return 32'h3C01_1234;
        return (a ^ 32'h5A5A_0F0F) + {a[15:0], a[31:16]};
    endfunction

    assign instr_readdata = mem_word(instr_address);

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Leaves the bench 1ns after a rising edge with reset released.
    task automatic do_reset();
        reset             = 1'b1;
        instr_waitrequest = 1'b1;
        stall             = 1'b0;
        redirect_valid    = 1'b0;
        redirect_target   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_read",   instr_read,  0);
        check("rst_valid",  instr_valid, 0);
        check("rst_active", active,      1);
        check("rst_pc",     pc,          RV);
        check("rst_pc4",    pc_plus4,    RV + 32'd4);
        check("rst_instr",  instr,       32'h0);
        reset = 1'b0;
    endtask

    task automatic check_hold(input logic [31:0] exp_pc);
        logic [31:0] w;
        w = mem_word(exp_pc);
        check("hold_valid",  instr_valid,     1);
        check("hold_read",   instr_read,      0);
        check("hold_active", active,          1);
        check("hold_pc",     pc,              exp_pc);
        check("hold_pc4",    pc_plus4,        exp_pc + 32'd4);
        check("hold_instr",  instr,           w);
        check("hold_opcode", {26'h0, opcode}, {26'h0, w[31:26]});
        check("hold_imm",    {16'h0, itype_immediate}, {16'h0, w[15:0]});
    endtask

    // One instruction: fetch with wait states, hold with stalls (and an
    // ignored redirect), then consume with the given redirect.
    task automatic step_instr(input int wait_cycles, input int stall_cycles,
                              input logic rv, input logic [31:0] rt,
                              input logic [31:0] exp_pc);
        for (int w = 0; w <= wait_cycles; w++) begin
            instr_waitrequest = (w < wait_cycles);
            @(negedge clk);
            check("fetch_read",  instr_read,    1);
            check("fetch_valid", instr_valid,   0);
            check("fetch_addr",  instr_address, exp_pc);
            @(posedge clk); #1;
        end
        instr_waitrequest = 1'b1;
        @(negedge clk);
        check_hold(exp_pc);
        for (int s = 0; s < stall_cycles; s++) begin
            stall           = 1'b1;
            redirect_valid  = 1'b1;
            redirect_target = 32'h0;
            @(posedge clk); #1;
            @(negedge clk);
            check_hold(exp_pc);
        end
        stall           = 1'b0;
        redirect_valid  = rv;
        redirect_target = rt;
        @(posedge clk); #1;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
    endtask

    task automatic check_halted(input string tag);
        @(negedge clk);
        check({tag, "_active"}, active,      0);
        check({tag, "_read"},   instr_read,  0);
        check({tag, "_valid"},  instr_valid, 0);
        check({tag, "_pc"},     pc,          32'h0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        int          wait_cycles;
        int          stall_cycles;
        logic        rv;
        logic [31:0] rt;
        logic [31:0] exp_pc;
    } vec_t;

    task automatic random_phase(input int n_cycles);
        logic [31:0] m_pc;
        logic [31:0] q[$];
        logic [31:0] nxt;
        logic        m_valid;
        logic        m_halted;
        int          halt_cycles;
        logic        w, s, rv;
        logic [31:0] rt;
        do_reset();
        m_pc = RV; m_valid = 1'b0; m_halted = 1'b0; halt_cycles = 0; q.delete();
        for (int c = 0; c < n_cycles; c++) begin
            w  = ($urandom_range(0, 2) == 0);
            s  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 29))
                0:       rt = 32'h0;
                1:       rt = 32'hFFFF_FFF8 | $urandom_range(0, 7);
                default: rt = RV + $urandom_range(0, 1023);
            endcase
            instr_waitrequest = w;
            stall             = s;
            redirect_valid    = rv;
            redirect_target   = rt;
            @(negedge clk);
            check("rnd_active", active,      !m_halted);
            check("rnd_valid",  instr_valid, m_valid);
            check("rnd_read",   instr_read,  !m_halted && !m_valid);
            check("rnd_pc",     pc,          m_pc);
            if (m_valid) check("rnd_instr", instr, mem_word(m_pc));
            @(posedge clk);
            if (!m_halted) begin
                if (!m_valid) begin
                    if (!w) m_valid = 1'b1;
                end else if (!s) begin
                    nxt = (q.size() != 0) ? q.pop_front() : m_pc + 32'd4;
                    if (rv) q.push_back({rt[31:2], 2'b00});
                    m_pc     = nxt;
                    m_valid  = 1'b0;
                    m_halted = (nxt == 32'h0);
                end
            end
            #1;
            if (m_halted && (++halt_cycles > 3)) begin
                do_reset();
                m_pc = RV; m_valid = 1'b0; m_halted = 1'b0; halt_cycles = 0; q.delete();
            end
        end
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{0, 0, 1'b0, 32'h0,          RV};
        vecs[1] = '{3, 2, 1'b0, 32'h0,          RV + 32'h04};
        vecs[2] = '{1, 0, 1'b0, 32'h0,          RV + 32'h08};
        vecs[3] = '{0, 0, 1'b0, 32'h0,          RV + 32'h0C};
        vecs[4] = '{0, 1, 1'b1, 32'hBFC0_0103,  RV + 32'h10};
        vecs[5] = '{0, 0, 1'b0, 32'h0,          RV + 32'h14};
        vecs[6] = '{2, 0, 1'b1, 32'h0,          RV + 32'h100};
        vecs[7] = '{0, 0, 1'b0, 32'h0,          RV + 32'h104};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            step_instr(vecs[i].wait_cycles, vecs[i].stall_cycles,
                       vecs[i].rv, vecs[i].rt, vecs[i].exp_pc);
        end
        instr_waitrequest = 1'b0;
        repeat (4) check_halted("jmp0_halt");

        // Reset asserted mid-FETCH while the memory is still waiting.
        do_reset();
        step_instr(0, 0, 1'b0, 32'h0, RV);
        instr_waitrequest = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_pre_addr", instr_address, RV + 32'd4);
        check("midrst_pre_read", instr_read,    1);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_read",  instr_read,  0);
        check("midrst_pc",    pc,          RV);
        check("midrst_valid", instr_valid, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Clean restart, then a redirect to the top of memory so pc+4 wraps to 0.
        step_instr(0, 0, 1'b1, 32'hFFFF_FFFF, RV);
        step_instr(1, 0, 1'b0, 32'h0,         RV + 32'd4);
        step_instr(0, 1, 1'b0, 32'h0,         32'hFFFF_FFFC);
        repeat (2) check_halted("wrap_halt");

        random_phase(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage of the MIPS CPU: holds the PC, reads instruction words over a waitrequest memory interface and latches them into an instruction register.
- Presents the current instruction to decode as decoded fields; opcode and itype_immediate feed sign_extension directly.
- Honours MIPS branch-delay-slot semantics and signals halt when control transfers to address 0.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
- HALT_ADDR, 32'h00000000, target address that halts the CPU.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- instr_address  output  32  word address of the fetch; equals pc.
- instr_read  output  1  memory read request.
- instr_waitrequest  input  1  memory not ready; hold request stable.
- instr_readdata  input  32  instruction word, valid when read && !waitrequest.
- stall  input  1  downstream cannot accept the held instruction this cycle.
- redirect_valid  input  1  consumed instruction is a taken branch/jump.
- redirect_target  input  32  branch/jump destination.
- instr_valid  output  1  instr/pc fields valid.
- instr  output  32  instruction register.
- opcode  output  6  instr[31:26].
- itype_immediate  output  16  instr[15:0].
- pc  output  32  address of the held instruction.
- pc_plus4  output  32  pc + 4, for link registers.
- active  output  1  high until halted.

Behaviour:
- Reset values (asynchronous): state=FETCH, pc=RESET_VECTOR, instr=0, instr_valid=0, pending=0, pending_target=0, active=1. Aborting an in-flight read is legal; instr_read follows state combinationally.
- States:
  - FETCH: instr_read=1, instr_valid=0.
  - HOLD: instr_read=0, instr_valid=1.
  - HALTED: instr_read=0, instr_valid=0, active=0.
- FETCH to HOLD: on the edge where instr_waitrequest=0, latch instr_readdata. instr_address must stay stable while waitrequest=1. Minimum latency is 1 cycle from request to instr_valid.
- HOLD consume: an edge with stall=0 consumes the instruction. If stall=1, stay in HOLD with all outputs frozen.
- Next PC on consume:
  - If pending=1: next=pending_target, then clear pending.
  - Otherwise: next=pc+4.
  - If redirect_valid=1 at consume (delay-slot semantics): pending<=1, pending_target<={redirect_target[31:2],2'b00}, next=pc+4. If pending was also 1, the new redirect is stored and the old target is still used for this step.
- After consume: if next==HALT_ADDR, go to HALTED, with pc=next and active=0 on the following cycle. Otherwise pc<=next and go to FETCH.
- Throughput: 1 instruction per 2 cycles with zero-wait memory.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFFFFFC to 0). A wrap to 0 counts as a halt.
- redirect_valid and redirect_target are ignored outside a consume edge.
- HALTED is absorbing; only reset leaves it.
- pc_plus4 is combinational pc+4.

Decomposition:
- package.v: state enum typedef (FETCH/HOLD/HALTED) and INSTR_NOP constant (32'h0).
- The existing OPCODE_* constants stay in package.v.
- Natural sub-module: pc_register (pc, pending, pending_target and next-PC mux). The FSM and instruction register stay in instruction_fetch.

Test Plan:
- Reset, then memory with waitrequest=0 returning 32'h3C011234 at 0xBFC00000 → instr_read in cycle 1; instr_valid in cycle 2; opcode=6'h0F; itype_immediate=16'h1234; pc=BFC00000; pc_plus4=BFC00004.
- waitrequest held high for 3 cycles → instr_address stable at BFC00000 for 4 cycles; instr_valid only after the low cycle.
- stall=1 for 2 cycles in HOLD → instr and pc frozen, instr_read=0; consume on the 3rd cycle → fetch at pc+4.
- Branch consumed at BFC00010 with redirect_valid=1, target=BFC00103 → fetches BFC00014 (delay slot), then BFC00100.
- Jump consumed with redirect_target=0 → delay slot at pc+4 executes; after its consume, active=0, instr_read=0 permanently.
- Reset asserted mid-FETCH with waitrequest=1 → instr_read low and pc=BFC00000 in the same cycle; restart is clean after release.
